// File: rtl/rice_inst_decode_stage_pkg.sv
// Purpose: RISC-V opcode/format encodings and the XLEN-independent decode of one instruction.
// Latency: n/a (types, constants and a combinational helper function).
// Backpressure: n/a.
// Contents: immediate-width constants, rice_opcode_e, rice_inst_type_e,
//           rice_riscv_inst_info and get_inst_info().
package rice_inst_decode_stage_pkg;

    // Width of the immediate field as encoded in the instruction word
    localparam int unsigned IMM_I_W = 12;
    localparam int unsigned IMM_S_W = 12;
    localparam int unsigned IMM_B_W = 13;
    localparam int unsigned IMM_U_W = 20;
    localparam int unsigned IMM_J_W = 21;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } rice_opcode_e;

    // Illegal encodings are reported as TYPE_R so their immediate reads as zero
    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } rice_inst_type_e;

    typedef struct packed {
        logic [6:0]      opcode;
        rice_inst_type_e inst_type;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_write;
        logic            illegal;
    } rice_riscv_inst_info;

    function automatic rice_riscv_inst_info get_inst_info(input logic [31:0] inst);
        rice_riscv_inst_info info;
        logic known;
        logic sys_csr_reg;
        logic sys_no_rd;
        info           = '0;
        info.opcode    = inst[6:0];
        info.funct3    = inst[14:12];
        info.funct7    = inst[31:25];
        info.rs1       = inst[19:15];
        info.rs2       = inst[24:20];
        info.rd        = inst[11:7];
        info.inst_type = TYPE_R;
        known          = 1'b1;
        case (inst[6:0])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: info.inst_type = TYPE_I;
            OPC_STORE:            info.inst_type = TYPE_S;
            OPC_BRANCH:           info.inst_type = TYPE_B;
            OPC_LUI, OPC_AUIPC:   info.inst_type = TYPE_U;
            OPC_JAL:              info.inst_type = TYPE_J;
            OPC_OP:               info.inst_type = TYPE_R;
            default:              known = 1'b0;
        endcase
        info.illegal = !known || (inst[1:0] != 2'b11) || (inst == 32'd0);
        // CSRRW/CSRRS/CSRRC read rs1; the immediate CSR forms reuse the field as zimm
        sys_csr_reg = (inst[6:0] == OPC_SYSTEM) && (inst[14:12] inside {3'd1, 3'd2, 3'd3});
        // ECALL/EBREAK/xRET and fences never write a register even with rd != 0
        sys_no_rd   = (inst[6:0] == OPC_MISC_MEM) ||
                      ((inst[6:0] == OPC_SYSTEM) && (inst[14:12] == 3'd0));
        info.rs2_used = !info.illegal &&
                        (info.inst_type inside {TYPE_R, TYPE_S, TYPE_B});
        info.rs1_used = !info.illegal &&
                        ((info.inst_type inside {TYPE_R, TYPE_S, TYPE_B}) ||
                         (inst[6:0] inside {OPC_JALR, OPC_LOAD, OPC_OP_IMM}) || sys_csr_reg);
        info.rd_write = !info.illegal && (inst[11:7] != 5'd0) && !sys_no_rd &&
                        (info.inst_type inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J});
        return info;
    endfunction

endpackage

// File: rtl/rice_inst_decode_stage_if.sv
// Purpose: fetch-side and execute-side handshake/data bundle of the decode stage.
// Latency: n/a (wires only).
// Backpressure: carries i_inst_valid/o_inst_ready and o_dec_valid/i_dec_ready.
// Modports: slave = decode stage view, master = fetch/execute (environment) view.
interface rice_inst_decode_stage_if #(
    parameter int XLEN = 32
);
    import rice_inst_decode_stage_pkg::*;

    logic            i_inst_valid;
    logic            o_inst_ready;
    logic [31:0]     i_inst;
    logic [XLEN-1:0] i_pc;
    logic            o_dec_valid;
    logic            i_dec_ready;
    logic [XLEN-1:0] o_pc;
    logic [6:0]      o_opcode;
    rice_inst_type_e o_inst_type;
    logic [2:0]      o_funct3;
    logic [6:0]      o_funct7;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [4:0]      o_rd;
    logic            o_rs1_used;
    logic            o_rs2_used;
    logic            o_rd_write;
    logic [XLEN-1:0] o_imm;
    logic            o_illegal;

    modport slave (
        input  i_inst_valid, i_inst, i_pc, i_dec_ready,
        output o_inst_ready, o_dec_valid, o_pc, o_opcode, o_inst_type, o_funct3, o_funct7,
               o_rs1, o_rs2, o_rd, o_rs1_used, o_rs2_used, o_rd_write, o_imm, o_illegal
    );

    modport master (
        output i_inst_valid, i_inst, i_pc, i_dec_ready,
        input  o_inst_ready, o_dec_valid, o_pc, o_opcode, o_inst_type, o_funct3, o_funct7,
               o_rs1, o_rs2, o_rd, o_rs1_used, o_rs2_used, o_rd_write, o_imm, o_illegal
    );

endinterface

// File: rtl/rice_skid_buffer.sv
// Purpose: registered valid/ready pipeline stage, optionally with a one-entry skid register.
// Latency: 1 cycle from input accept to output valid.
// Backpressure: SKID_BUFFER=1 ready comes from a flop (low only while skid holds data);
//               SKID_BUFFER=0 ready = !o_valid || i_ready (combinational). i_flush empties all.
// Ports: i_valid/o_ready/i_data upstream, o_valid/i_ready/o_data downstream.
module rice_skid_buffer #(
    parameter int WIDTH       = 8,
    parameter bit SKID_BUFFER = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             out_free;   // output register empty or draining this cycle

    assign o_valid  = out_vld_q;
    assign o_data   = out_dat_q;
    assign out_free = !out_vld_q || i_ready;

    generate
        if (SKID_BUFFER) begin : g_skid
            logic             skid_vld_q, skid_vld_d;
            logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
            logic             rdy_q;
            logic             in_fire;

            assign o_ready = rdy_q;
            assign in_fire = i_valid && rdy_q;

            // rdy_q mirrors !skid_vld_q, so an accept never coincides with a full skid
            always_comb begin
                out_vld_d  = out_vld_q;
                out_dat_d  = out_dat_q;
                skid_vld_d = skid_vld_q;
                skid_dat_d = skid_dat_q;
                if (i_flush) begin
                    out_vld_d  = 1'b0;
                    skid_vld_d = 1'b0;
                end else if (out_free) begin
                    if (skid_vld_q) begin
                        out_vld_d  = 1'b1;
                        out_dat_d  = skid_dat_q;
                        skid_vld_d = 1'b0;
                    end else begin
                        out_vld_d = in_fire;
                        if (in_fire) out_dat_d = i_data;
                    end
                end else if (in_fire) begin
                    skid_vld_d = 1'b1;
                    skid_dat_d = i_data;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    skid_vld_q <= 1'b0;
                    skid_dat_q <= '0;
                    rdy_q      <= 1'b1;
                end else begin
                    skid_vld_q <= skid_vld_d;
                    skid_dat_q <= skid_dat_d;
                    rdy_q      <= !skid_vld_d;
                end
            end
        end else begin : g_pass
            assign o_ready = out_free;

            always_comb begin
                out_vld_d = out_vld_q;
                out_dat_d = out_dat_q;
                if (i_flush) begin
                    out_vld_d = 1'b0;
                end else if (out_free) begin
                    out_vld_d = i_valid;
                    if (i_valid) out_dat_d = i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

endmodule

// File: rtl/rice_inst_decode_stage.sv
// Purpose: RV32I/RV64I decode stage: field split, format class, sign-extended immediate, flags.
// Latency: 1 cycle (accept in cycle N, decoded fields on outputs in cycle N+1).
// Backpressure: valid/ready both sides via rice_skid_buffer; i_flush drops held and incoming work.
// Ports: i_clk, i_rst (sync, active-high), i_flush, bus (slave modport: fetch in, decoded out).
module rice_inst_decode_stage
    import rice_inst_decode_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit SKID_BUFFER = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    rice_inst_decode_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        rice_riscv_inst_info info;
        logic [XLEN-1:0]     imm;
    } payload_t;

    rice_riscv_inst_info info;
    logic [31:0]         imm32;
    logic [31:0]         inst;
    payload_t            in_pl;
    payload_t            out_pl;

    assign inst = bus.i_inst;

    // Every immediate fits in 32 bits; a signed size cast widens it to XLEN
    always_comb begin
        info  = get_inst_info(inst);
        imm32 = '0;
        case (info.inst_type)
            TYPE_I:  imm32 = {{(32-IMM_I_W){inst[31]}}, inst[31:20]};
            TYPE_S:  imm32 = {{(32-IMM_S_W){inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:  imm32 = {{(32-IMM_B_W){inst[31]}}, inst[31], inst[7], inst[30:25],
                              inst[11:8], 1'b0};
            TYPE_U:  imm32 = {inst[31:32-IMM_U_W], 12'b0};
            TYPE_J:  imm32 = {{(32-IMM_J_W){inst[31]}}, inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        in_pl.pc   = bus.i_pc;
        in_pl.info = info;
        in_pl.imm  = XLEN'($signed(imm32));
    end

    rice_skid_buffer #(
        .WIDTH       ($bits(payload_t)),
        .SKID_BUFFER (SKID_BUFFER)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (bus.i_inst_valid),
        .o_ready (bus.o_inst_ready),
        .i_data  (in_pl),
        .o_valid (bus.o_dec_valid),
        .i_ready (bus.i_dec_ready),
        .o_data  (out_pl)
    );

    assign bus.o_pc        = out_pl.pc;
    assign bus.o_opcode    = out_pl.info.opcode;
    assign bus.o_inst_type = out_pl.info.inst_type;
    assign bus.o_funct3    = out_pl.info.funct3;
    assign bus.o_funct7    = out_pl.info.funct7;
    assign bus.o_rs1       = out_pl.info.rs1;
    assign bus.o_rs2       = out_pl.info.rs2;
    assign bus.o_rd        = out_pl.info.rd;
    assign bus.o_rs1_used  = out_pl.info.rs1_used;
    assign bus.o_rs2_used  = out_pl.info.rs2_used;
    assign bus.o_rd_write  = out_pl.info.rd_write;
    assign bus.o_illegal   = out_pl.info.illegal;
    assign bus.o_imm       = out_pl.imm;

endmodule

// File: tb/tb_rice_inst_decode_stage.sv
// Purpose: scoreboard bench for rice_inst_decode_stage (XLEN=32 with skid, XLEN=64 without).
// Latency: expects each accepted instruction on the outputs one cycle later, in order, once.
// Backpressure: drives stalls, skid fill, flush and combinational-ready scenarios.
module tb_rice_inst_decode_stage;
    import rice_inst_decode_stage_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  itype;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  flg;     // {rs1_used, rs2_used, rd_write, illegal}
        logic [63:0] imm;
    } dec_t;

    typedef struct packed {
        logic [31:0] inst;
        dec_t        exp;
    } vec_t;

    logic core_clk = 1'b0;
    logic rst      = 1'b1;
    logic flush32  = 1'b0;
    logic flush64  = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n32      = 0;
    int   n64      = 0;
    dec_t q32[$];
    dec_t q64[$];

    rice_inst_decode_stage_if #(.XLEN(32)) b32();
    rice_inst_decode_stage_if #(.XLEN(64)) b64();

    rice_inst_decode_stage #(.XLEN(32), .SKID_BUFFER(1'b1)) dut32 (
        .i_clk(core_clk), .i_rst(rst), .i_flush(flush32), .bus(b32));
    rice_inst_decode_stage #(.XLEN(64), .SKID_BUFFER(1'b0)) dut64 (
        .i_clk(core_clk), .i_rst(rst), .i_flush(flush64), .bus(b64));

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] pc,
                                input logic [2:0] t, input logic [3:0] flg, input logic [63:0] imm);
        vec_t v;
        v.inst       = inst;
        v.exp.pc     = pc;
        v.exp.opcode = inst[6:0];
        v.exp.itype  = t;
        v.exp.funct3 = inst[14:12];
        v.exp.funct7 = inst[31:25];
        v.exp.rs1    = inst[19:15];
        v.exp.rs2    = inst[24:20];
        v.exp.rd     = inst[11:7];
        v.exp.flg    = flg;
        v.exp.imm    = imm;
        return v;
    endfunction

    function automatic dec_t obs32();
        dec_t d;
        d.pc = 64'(b32.o_pc); d.opcode = b32.o_opcode; d.itype = b32.o_inst_type;
        d.funct3 = b32.o_funct3; d.funct7 = b32.o_funct7;
        d.rs1 = b32.o_rs1; d.rs2 = b32.o_rs2; d.rd = b32.o_rd;
        d.flg = {b32.o_rs1_used, b32.o_rs2_used, b32.o_rd_write, b32.o_illegal};
        d.imm = 64'(b32.o_imm);
        return d;
    endfunction

    function automatic dec_t obs64();
        dec_t d;
        d.pc = b64.o_pc; d.opcode = b64.o_opcode; d.itype = b64.o_inst_type;
        d.funct3 = b64.o_funct3; d.funct7 = b64.o_funct7;
        d.rs1 = b64.o_rs1; d.rs2 = b64.o_rs2; d.rd = b64.o_rd;
        d.flg = {b64.o_rs1_used, b64.o_rs2_used, b64.o_rd_write, b64.o_illegal};
        d.imm = b64.o_imm;
        return d;
    endfunction

    // Monitors: an output transfer happens at the next posedge when valid&&ready at negedge
    always @(negedge core_clk) begin : mon32
        dec_t e;
        if (!rst && b32.o_dec_valid && b32.i_dec_ready) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("FAIL out32_unexpected got pc=%0h exp=no output", b32.o_pc);
            end else begin
                e = q32.pop_front();
                chk($sformatf("out32[%0d]", n32), 192'(obs32()), 192'(e));
                n32++;
            end
        end
    end

    always @(negedge core_clk) begin : mon64
        dec_t e;
        if (!rst && b64.o_dec_valid && b64.i_dec_ready) begin
            if (q64.size() == 0) begin
                checks++; failures++;
                $display("FAIL out64_unexpected got pc=%0h exp=no output", b64.o_pc);
            end else begin
                e = q64.pop_front();
                chk($sformatf("out64[%0d]", n64), 192'(obs64()), 192'(e));
                n64++;
            end
        end
    end

    // Hold valid and data until accepted; expected record is queued only when push is set
    task automatic send32(input vec_t v, input bit push);
        int n;
        n = 0;
        b32.i_inst_valid = 1'b1;
        b32.i_inst       = v.inst;
        b32.i_pc         = v.exp.pc[31:0];
        forever begin
            @(negedge core_clk);
            if (b32.o_inst_ready) break;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send32_timeout got ready=0 exp ready=1");
                break;
            end
        end
        if (push) q32.push_back(v.exp);
        @(posedge core_clk); #1;
    endtask

    task automatic send64(input vec_t v);
        int n;
        n = 0;
        b64.i_inst_valid = 1'b1;
        b64.i_inst       = v.inst;
        b64.i_pc         = v.exp.pc;
        forever begin
            @(negedge core_clk);
            if (b64.o_inst_ready) break;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send64_timeout got ready=0 exp ready=1");
                break;
            end
        end
        q64.push_back(v.exp);
        @(posedge core_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t t32[$];
        vec_t t64[$];
        vec_t ill[$];
        int   t0;
        int   w;

        b32.i_inst_valid = 1'b0; b32.i_inst = '0; b32.i_pc = '0; b32.i_dec_ready = 1'b1;
        b64.i_inst_valid = 1'b0; b64.i_inst = '0; b64.i_pc = '0; b64.i_dec_ready = 1'b1;

        t32.push_back(mk(32'hFFF10093, 64'h1000, TYPE_I, 4'b1010, 64'hFFFFFFFF));
        t32.push_back(mk(32'hFE000EE3, 64'h1004, TYPE_B, 4'b1100, 64'hFFFFFFFC));
        t32.push_back(mk(32'h00512423, 64'h1008, TYPE_S, 4'b1100, 64'h8));
        t32.push_back(mk(32'h002081B3, 64'h100C, TYPE_R, 4'b1110, 64'h0));
        t32.push_back(mk(32'h123452B7, 64'h1010, TYPE_U, 4'b0010, 64'h12345000));
        t32.push_back(mk(32'h001000EF, 64'h1014, TYPE_J, 4'b0010, 64'h800));
        t32.push_back(mk(32'h00008067, 64'h1018, TYPE_I, 4'b1000, 64'h0));
        t32.push_back(mk(32'h00000073, 64'h101C, TYPE_I, 4'b0000, 64'h0));
        t32.push_back(mk(32'h300022F3, 64'h1020, TYPE_I, 4'b1010, 64'h300));
        t32.push_back(mk(32'h3002D2F3, 64'h1024, TYPE_I, 4'b0010, 64'h300));
        t32.push_back(mk(32'h0FF0000F, 64'h1028, TYPE_I, 4'b0000, 64'hFF));
        t32.push_back(mk(32'hFF812303, 64'h102C, TYPE_I, 4'b1010, 64'hFFFFFFF8));
        t32.push_back(mk(32'h80000397, 64'h1030, TYPE_U, 4'b0010, 64'h80000000));

        ill.push_back(mk(32'h00000000, 64'h4000, TYPE_R, 4'b0001, 64'h0));
        ill.push_back(mk(32'hFFFFFFFF, 64'h4004, TYPE_R, 4'b0001, 64'h0));
        ill.push_back(mk(32'h00000001, 64'h4008, TYPE_R, 4'b0001, 64'h0));
        ill.push_back(mk(32'h002081BB, 64'h400C, TYPE_R, 4'b0001, 64'h0));
        ill.push_back(mk(32'h00000013, 64'h4010, TYPE_I, 4'b1000, 64'h0));

        t64.push_back(mk(32'h123452B7, 64'h1_0000_0000, TYPE_U, 4'b0010, 64'h0000000012345000));
        t64.push_back(mk(32'h800002B7, 64'h1_0000_0004, TYPE_U, 4'b0010, 64'hFFFFFFFF80000000));
        t64.push_back(mk(32'hFFF10093, 64'h1_0000_0008, TYPE_I, 4'b1010, 64'hFFFFFFFFFFFFFFFF));
        t64.push_back(mk(32'h001000EF, 64'h1_0000_000C, TYPE_J, 4'b0010, 64'h800));
        t64.push_back(mk(32'hFE000EE3, 64'h1_0000_0010, TYPE_B, 4'b1100, 64'hFFFFFFFFFFFFFFFC));

        // Reset state
        repeat (3) @(posedge core_clk);
        #1 rst = 1'b0;
        @(negedge core_clk);
        chk("rst32_valid", b32.o_dec_valid, 1'b0);
        chk("rst32_ready", b32.o_inst_ready, 1'b1);
        chk("rst32_data", 192'(obs32()), 192'd0);
        chk("rst64_valid", b64.o_dec_valid, 1'b0);
        chk("rst64_ready", b64.o_inst_ready, 1'b1);
        chk("rst64_data", 192'(obs64()), 192'd0);
        @(posedge core_clk); #1;

        // Back-to-back stream: one accept per cycle
        t0 = cyc;
        foreach (t32[i]) send32(t32[i], 1'b1);
        b32.i_inst_valid = 1'b0;
        chk("throughput32_cycles", cyc - t0, t32.size());
        repeat (3) @(posedge core_clk); #1;

        // Skid fill: A on output, B in skid, C held until release
        b32.i_dec_ready = 1'b0;
        fork
            begin
                send32(mk(32'h00512423, 64'h2000, TYPE_S, 4'b1100, 64'h8), 1'b1);
                send32(mk(32'h002081B3, 64'h2004, TYPE_R, 4'b1110, 64'h0), 1'b1);
                send32(mk(32'h123452B7, 64'h2008, TYPE_U, 4'b0010, 64'h12345000), 1'b1);
                b32.i_inst_valid = 1'b0;
            end
            begin
                int k;
                repeat (3) @(negedge core_clk);
                chk("skid_ready_low", b32.o_inst_ready, 1'b0);
                chk("skid_head_valid", b32.o_dec_valid, 1'b1);
                chk("skid_head_pc", b32.o_pc, 32'h2000);
                @(negedge core_clk);
                chk("skid_hold_ready", b32.o_inst_ready, 1'b0);
                @(posedge core_clk); #1;
                b32.i_dec_ready = 1'b1;
                k = 0;
                do begin
                    @(negedge core_clk); #1;
                    k++;
                end while (q32.size() != 0 && k < 20);
                chk("skid_drain_cycles", k, 3);
            end
        join
        @(posedge core_clk); #1;

        // Flush with output and skid full plus a new valid input: nothing may emerge
        b32.i_dec_ready = 1'b0;
        send32(mk(32'hFFF10093, 64'h3000, TYPE_I, 4'b1010, 64'hFFFFFFFF), 1'b0);
        send32(mk(32'hFFF10093, 64'h3004, TYPE_I, 4'b1010, 64'hFFFFFFFF), 1'b0);
        b32.i_inst_valid = 1'b1;
        b32.i_inst       = 32'h00000013;
        b32.i_pc         = 32'h3008;
        flush32          = 1'b1;
        @(negedge core_clk);
        chk("flush_pre_full", {b32.o_dec_valid, b32.o_inst_ready}, 2'b10);
        @(posedge core_clk); #1;
        flush32          = 1'b0;
        b32.i_inst_valid = 1'b0;
        @(negedge core_clk);
        chk("flush_valid", b32.o_dec_valid, 1'b0);
        chk("flush_ready", b32.o_inst_ready, 1'b1);
        b32.i_dec_ready = 1'b1;
        repeat (4) @(negedge core_clk);
        @(posedge core_clk); #1;

        // Illegal encodings and nop
        foreach (ill[i]) send32(ill[i], 1'b1);
        b32.i_inst_valid = 1'b0;

        // XLEN=64, combinational-ready variant
        foreach (t64[i]) send64(t64[i]);
        b64.i_inst_valid = 1'b0;
        @(posedge core_clk); #1;
        b64.i_dec_ready = 1'b0;
        send64(mk(32'h00512423, 64'hFFFF_0000_0000_0000, TYPE_S, 4'b1100, 64'h8));
        b64.i_inst_valid = 1'b1;
        b64.i_inst       = 32'h002081B3;
        b64.i_pc         = 64'hFFFF_0000_0000_0004;
        #2;
        chk("pass64_ready_stalled", b64.o_inst_ready, 1'b0);
        b64.i_dec_ready = 1'b1;
        #1;
        chk("pass64_ready_comb", b64.o_inst_ready, 1'b1);
        send64(mk(32'h002081B3, 64'hFFFF_0000_0000_0004, TYPE_R, 4'b1110, 64'h0));
        b64.i_inst_valid = 1'b0;

        // Drain both scoreboards
        w = 0;
        while ((q32.size() != 0 || q64.size() != 0) && w < 50) begin
            @(negedge core_clk); #1;
            w++;
        end
        chk("drain32_left", q32.size(), 0);
        chk("drain64_left", q64.size(), 0);
        chk("delivered32", n32, t32.size() + 3 + ill.size());
        chk("delivered64", n64, t64.size() + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
